// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end. Owns the PC, issues pipelined
//            requests to instruction memory, tracks in-flight requests in an
//            in-order PC queue and buffers returned words in a FIFO that is
//            presented to decode with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
   parameter int          XLEN            = 64,
   parameter logic [63:0] RESET_VECTOR    = 64'h0,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [XLEN-1:0] inst_pc
);

   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int QN = 2 ** QW;
   localparam int SW = ((CW > OW) ? CW : OW) + 1;
   localparam logic [XLEN-1:0] RESET_PC = RESET_VECTOR[XLEN-1:0] & ~XLEN'(3);

   logic [XLEN-1:0] fetch_pc;

   // PC of every issued-but-unanswered request, oldest first
   logic [XLEN-1:0] pcq [QN];
   logic [QW-1:0]   pcq_wr;
   logic [QW-1:0]   pcq_rd;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;

   // Instruction buffer
   logic [31:0]     fifo_data [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
   logic [FW-1:0]   wr_ptr;
   logic [FW-1:0]   rd_ptr;
   logic [CW-1:0]   fifo_count;

   logic [SW-1:0]   credit_used;
   logic            req_fire;
   logic            resp_take;
   logic            resp_drop;
   logic            push;
   logic            pop;

   function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
      return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
   endfunction

   // Buffered entries plus in-flight requests must fit in the FIFO, so a
   // response always has a slot when it lands.
   assign credit_used    = SW'(fifo_count) + SW'(outstanding);
   assign imem_req_valid = rst_n & run & ~redirect_valid
                         & (credit_used < SW'(FIFO_DEPTH))
                         & (outstanding < OW'(MAX_OUTSTANDING));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_take = imem_resp_valid & (outstanding != '0);
   assign resp_drop = resp_take & (discard != '0);
   // A response landing in a redirect cycle is stale and would be flushed.
   assign push      = resp_take & ~resp_drop & ~redirect_valid;
   assign pop       = inst_valid & inst_ready;

   assign inst_valid = (fifo_count != '0);
   assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
   assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

   // Fetch PC: redirect target (word aligned) or advance on each accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~XLEN'(3);
      end else if (req_fire) begin
         fetch_pc <= fetch_pc + XLEN'(4);
      end
   end

   // PC queue storage: record the address of each accepted request
   always_ff @(posedge clk) begin
      if (req_fire) begin
         pcq[pcq_wr] <= fetch_pc;
      end
   end

   // In-flight bookkeeping: queue pointers, outstanding and stale-response count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcq_wr      <= '0;
         pcq_rd      <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         if (req_fire) begin
            pcq_wr <= q_next(pcq_wr);
         end
         if (resp_take) begin
            pcq_rd <= q_next(pcq_rd);
         end
         case ({req_fire, resp_take})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: ;
         endcase
         // Every request still in flight after a redirect edge is stale,
         // including ones already marked stale by an earlier redirect.
         if (redirect_valid) begin
            discard <= outstanding - OW'(resp_take);
         end else if (resp_drop) begin
            discard <= discard - OW'(1);
         end
      end
   end

   // FIFO storage: write returned word with its PC from the queue head
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= imem_resp_data;
         fifo_pc[wr_ptr]   <= pcq[pcq_rd];
      end
   end

   // FIFO pointers and occupancy; redirect empties the buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (redirect_valid) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + FW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-cycle PC-plus-4 fetch path.
- Owns the PC, issues pipelined requests to instruction memory over a valid/ready interface, and buffers returned instructions in an in-order FIFO.
- Presents instructions to decode/execute with a valid/ready handshake.
- Supports run gating, branch/jump redirect with flush, and discarding of in-flight stale responses.

Parameters:
- XLEN, 64, PC/address width in bits.
- RESET_VECTOR, 64'h0, PC value after reset (XLEN bits used, 4-byte aligned).
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2).
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered imem requests (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable; 0 stops new request issue only.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request byte address, always 4-byte aligned.
- imem_resp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle redirect pulse.
- redirect_pc  in  XLEN  redirect target.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  consumer accepts head.
- inst_data  out  32  head instruction.
- inst_pc  out  XLEN  head instruction PC.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_VECTOR, FIFO empty, outstanding=0, discard=0. Outputs during reset: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_VECTOR, inst_data=0, inst_pc=0.
- Issue: imem_req_valid = run & ~redirect_valid & (fifo_count + outstanding < FIFO_DEPTH) & (outstanding < MAX_OUTSTANDING).
  - imem_req_addr=fetch_pc.
  - Request fires on valid&ready: fetch_pc += 4 (mod 2^XLEN, wraps to 0), outstanding++.
  - A request with ready low holds its address stable.
  - Valid is not required to stay high if run drops.
- The credit rule guarantees the FIFO never overflows; FIFO full blocks issue and never drops data.
- Response: on imem_resp_valid with discard>0, drop the word and decrement discard. Otherwise push {pc, data}, where pc is the in-order PC queue entry. Outstanding decrements in both cases.
- A response with outstanding=0 and discard=0 is a protocol error: ignored, no state change.
- Output: inst_valid = FIFO non-empty. Pop on inst_valid&inst_ready. Push and pop in the same cycle are both allowed, including when full.
- Zero-latency bypass is not allowed: a pushed entry becomes visible at the head the cycle after the push.
- Redirect (redirect_valid=1), next cycle:
  - FIFO flushed; a same-cycle pop still counts as delivered.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - discard = outstanding at that edge, i.e. current outstanding minus any response arriving this cycle. No request fires in the redirect cycle.
  - outstanding keeps counting stale requests until their responses drain.
- Redirect while discard>0: discard accumulates correctly (new discard = all remaining in-flight responses).
- run=0: in-flight responses still land; FIFO still drains; PC frozen.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after reset release for pre-reset requests are outside the contract; memory is reset together with this block.
- Total latency, request accept to inst_valid: response cycle + 1.

Test Plan:
- Reset release, run=1, imem ready always, 1-cycle response → request addresses 0x0, 0x4, 0x8…; first inst_valid with inst_pc=0x0; back-to-back delivery with inst_ready=1.
- inst_ready=0 for 10 cycles, DEPTH=4 → at most 4 requests issued; imem_req_valid low once credits are exhausted; after ready, 4 entries drain in PC order with no loss.
- imem_req_ready toggling 1-0-1 → imem_req_addr held while ready=0; no duplicate or skipped PCs.
- Redirect to 0x1002 with 2 requests outstanding → both responses dropped; next request addr 0x1000; first delivered inst_pc=0x1000; FIFO empty in the cycle after redirect.
- Redirect in the same cycle as inst handshake and an arriving response → popped entry delivered once; arriving response dropped; no stale PC ever appears.
- RESET_VECTOR=64'hFFFF_FFFF_FFFF_FFF8 → addresses …FFF8, …FFFC, 0x0; run=0 mid-stream stops issue while buffered entries still drain.
